// File: rtl/seg7_capture_encoder_if.sv
// Handshake bundle carrying a decoded digit from the capture encoder to its consumer.
interface seg7_capture_encoder_if;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic       out_ready;

  modport master (
    output out_valid,
    output out_digit,
    output out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_digit,
    input  out_err,
    output out_ready
  );
endinterface

// File: rtl/seg7_capture_encoder.sv
// Samples an active-low 7-segment bus, waits for a stable pattern and presents each newly
// settled pattern once as a digit (or an error code) on a valid/ready handshake.
module seg7_capture_encoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          Resetn,
  input  logic [6:0]                    HEX_IN,  // bit 0 = segment a ... bit 6 = segment g
  seg7_capture_encoder_if.master        hs
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [6:0] Blank = 7'h7f;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSettle  = 2'd1;
  localparam logic [1:0] StPresent = 2'd2;

  logic [6:0]      sync1_q, sync2_q;
  logic [6:0]      cand_q, cand_d;
  logic [6:0]      last_pat_q, last_pat_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      state_q, state_d;
  logic            valid_q, valid_d;
  logic [3:0]      digit_q, digit_d;
  logic            err_q, err_d;

  logic            is_digit;
  logic [3:0]      cand_val;

  // Patterns stored with segment a in bit 0, so these read g..a left to right.
  always_comb begin
    is_digit = 1'b1;
    cand_val = 4'd0;
    case (cand_q)
      7'b1000000: cand_val = 4'd0;
      7'b1111001: cand_val = 4'd1;
      7'b0100100: cand_val = 4'd2;
      7'b0110000: cand_val = 4'd3;
      7'b0011001: cand_val = 4'd4;
      7'b0010010: cand_val = 4'd5;
      7'b0000010: cand_val = 4'd6;
      7'b1111000: cand_val = 4'd7;
      7'b0000000: cand_val = 4'd8;
      7'b0010000: cand_val = 4'd9;
      default:    is_digit = 1'b0;
    endcase
  end

  always_comb begin
    cand_d     = cand_q;
    last_pat_d = last_pat_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    valid_d    = valid_q;
    digit_d    = digit_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (sync2_q != last_pat_q) begin
          cand_d  = sync2_q;
          cnt_d   = CntOne;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = CntOne;
        end else if (cnt_q < CntMax) begin
          cnt_d = cnt_q + CntOne;
        end else begin
          last_pat_d = cand_q;
          state_d    = StIdle;
          // Settling back to the previous pattern, or to blank, is not news.
          if ((cand_q != last_pat_q) && (cand_q != Blank)) begin
            valid_d = 1'b1;
            digit_d = is_digit ? cand_val : 4'hf;
            err_d   = ~is_digit;
            state_d = StPresent;
          end
        end
      end
      StPresent: begin
        if (hs.out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q    <= Blank;
      sync2_q    <= Blank;
      cand_q     <= Blank;
      last_pat_q <= Blank;
      cnt_q      <= '0;
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      digit_q    <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= HEX_IN;
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      last_pat_q <= last_pat_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      digit_q    <= digit_d;
      err_q      <= err_d;
    end
  end

  assign hs.out_valid = valid_q;
  assign hs.out_digit = digit_q;
  assign hs.out_err   = err_q;

endmodule

// File: tb/tb_seg7_capture_encoder.sv
// Bench for seg7_capture_encoder: directed latency/handshake scenarios plus randomized
// pattern sequences scored against a transfer-level model.
module tb_seg7_capture_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] hex = 7'h7f;

  int n_cmp = 0;
  int n_fail = 0;
  logic [4:0] xfer_q[$];
  logic [4:0] exp_q[$];

  seg7_capture_encoder_if bus ();

  seg7_capture_encoder #(.STABLE_CYCLES(4)) dut (
    .CLOCK_50 (clk),
    .Resetn   (rst_n),
    .HEX_IN   (hex),
    .hs       (bus.master)
  );

  always #5 clk = ~clk;

  // A transfer happens at the posedge following a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) xfer_q.push_back({bus.out_err, bus.out_digit});
  end

  // Patterns written a..g left to right, converted to the port order (a in bit 0).
  function automatic logic [6:0] seg(input logic [6:0] s);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = s[6-i];
    return r;
  endfunction

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return seg(7'b0000001);
      1: return seg(7'b1001111);
      2: return seg(7'b0010010);
      3: return seg(7'b0000110);
      4: return seg(7'b1001100);
      5: return seg(7'b0100100);
      6: return seg(7'b0100000);
      7: return seg(7'b0001111);
      8: return seg(7'b0000000);
      default: return seg(7'b0000100);
    endcase
  endfunction

  function automatic logic [4:0] model_code(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (digit_pat(d) == p) return {1'b0, 4'(d)};
    return {1'b1, 4'hf};
  endfunction

  function automatic logic [6:0] rand_pat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return digit_pat($urandom_range(0, 9));
    if (r < 7) return 7'h7f;
    return 7'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    hex = seg(7'b0000000);
    repeat (3) tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_digit !== 4'd0 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h e=%b want v=0 d=0 e=0",
               bus.out_valid, bus.out_digit, bus.out_err);
    end
    rst_n = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_early_valid: got %b want 0 after 6 edges", bus.out_valid);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd8 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_digit: got v=%b d=%h e=%b want v=1 d=8 e=0",
               bus.out_valid, bus.out_digit, bus.out_err);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_hold_digit();
    int bad;
    hex = digit_pat(2);
    repeat (6) tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_early_valid: got %b want 0", bus.out_valid);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd2 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_digit: got v=%b d=%h e=%b want v=1 d=2 e=0",
               bus.out_valid, bus.out_digit, bus.out_err);
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (!(bus.out_valid === 1'b1 && bus.out_digit === 4'd2 && bus.out_err === 1'b0)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
    end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_accept_drop: got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_glitch();
    xfer_q.delete();
    bus.out_ready = 1'b1;
    hex = digit_pat(1);
    repeat (2) tick();
    hex = digit_pat(3);
    repeat (20) tick();
    n_cmp++;
    if (xfer_q.size() != 1) begin
      n_fail++;
      $display("FAIL glitch_count: got %0d transfers want 1", xfer_q.size());
    end else begin
      n_cmp++;
      if (xfer_q[0] !== 5'h03) begin
        n_fail++;
        $display("FAIL glitch_digit: got %h want 03", xfer_q[0]);
      end
    end
  endtask

  task automatic test_invalid();
    bus.out_ready = 1'b0;
    hex = seg(7'b1111110);
    repeat (7) tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'hf || bus.out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_pattern: got v=%b d=%h e=%b want v=1 d=f e=1",
               bus.out_valid, bus.out_digit, bus.out_err);
    end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    xfer_q.delete();
    bus.out_ready = 1'b1;
    hex = digit_pat(2);
    repeat (50) tick();
    n_cmp++;
    if (xfer_q.size() != 1 || xfer_q[0] !== 5'h02) begin
      n_fail++;
      $display("FAIL repeat_first: got %0d transfers want exactly one of digit 2", xfer_q.size());
    end
    xfer_q.delete();
    hex = 7'h7f;
    repeat (8) tick();
    n_cmp++;
    if (xfer_q.size() != 0) begin
      n_fail++;
      $display("FAIL repeat_blank: got %0d transfers want 0", xfer_q.size());
    end
    hex = digit_pat(2);
    repeat (20) tick();
    n_cmp++;
    if (xfer_q.size() != 1 || xfer_q[0] !== 5'h02) begin
      n_fail++;
      $display("FAIL repeat_second: got %0d transfers want exactly one of digit 2",
               xfer_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    hex = digit_pat(5);
    repeat (7) tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_present: got v=%b d=%h want v=1 d=5", bus.out_valid, bus.out_digit);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_digit !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_async_clear: got v=%b d=%h want v=0 d=0",
               bus.out_valid, bus.out_digit);
    end
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_early_valid: got %b want 0", bus.out_valid);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd5 || bus.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rereport: got v=%b d=%h e=%b want v=1 d=5 e=0",
               bus.out_valid, bus.out_digit, bus.out_err);
    end
  endtask

  task automatic test_random();
    logic [6:0] prev;
    logic [6:0] p;
    int ng;
    int nmin;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    xfer_q.delete();
    exp_q.delete();
    prev = digit_pat(5);
    for (int i = 0; i < 40; i++) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        do p = rand_pat(); while (p == hex);
        hex = p;
        repeat ($urandom_range(1, 3)) tick();
      end
      p = rand_pat();
      hex = p;
      repeat ($urandom_range(12, 20)) tick();
      if (p != prev && p != 7'h7f) exp_q.push_back(model_code(p));
      prev = p;
    end
    repeat (12) tick();
    n_cmp++;
    if (xfer_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d transfers want %0d", xfer_q.size(), exp_q.size());
    end
    nmin = (xfer_q.size() < exp_q.size()) ? xfer_q.size() : exp_q.size();
    for (int k = 0; k < nmin; k++) begin
      n_cmp++;
      if (xfer_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL random_xfer[%0d]: got %h want %h", k, xfer_q[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_hold_digit();
    test_glitch();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
